// File: rtl/ctrl_pipe_pkg.sv
// ctrl_pipe_pkg: shared widths, stage indices, bundle layout and default stage masks for ctrl_pipe
package ctrl_pipe_pkg;
    localparam int CTRL_CW     = 13;
    localparam int CTRL_NSTAGE = 3;
    localparam int STG_E = 0;
    localparam int STG_M = 1;
    localparam int STG_W = 2;
    localparam int BIT_MEMTOREG   = 12;
    localparam int BIT_MEMWRITE   = 11;
    localparam int BIT_ALUSRC     = 10;
    localparam int BIT_REGDST     = 9;
    localparam int BIT_REGWRITE   = 8;
    localparam int ALUCONTROL_MSB = 7;
    localparam int ALUCONTROL_LSB = 0;
    localparam logic [CTRL_CW-1:0] MASK_E = '1;
    localparam logic [CTRL_CW-1:0] MASK_M = (CTRL_CW'(1) << BIT_MEMTOREG) | (CTRL_CW'(1) << BIT_MEMWRITE) | (CTRL_CW'(1) << BIT_REGWRITE);
    localparam logic [CTRL_CW-1:0] MASK_W = (CTRL_CW'(1) << BIT_MEMTOREG) | (CTRL_CW'(1) << BIT_REGWRITE);
    localparam logic [CTRL_NSTAGE*CTRL_CW-1:0] CTRL_STAGE_MASK = {MASK_W, MASK_M, MASK_E};
    typedef enum logic [1:0] {
        STAGE_CLEAR,
        STAGE_HOLD,
        STAGE_BUBBLE,
        STAGE_LOAD
    } stage_op_e;
endpackage

// File: rtl/ctrl_pipe_stage.sv
// ctrl_pipe_stage: one masked control register with valid, priority rst > flush > hold > bubble > load
module ctrl_pipe_stage
    import ctrl_pipe_pkg::*;
#(
    parameter int CW = CTRL_CW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          hold,
    input  logic          bubble,
    input  logic [CW-1:0] ctrl_in,
    input  logic          valid_in,
    input  logic [CW-1:0] mask,
    output logic [CW-1:0] ctrl,
    output logic          valid
);
    stage_op_e op;

    // flush beats hold, hold beats bubble, otherwise advance
    always_comb op = flush ? STAGE_CLEAR : hold ? STAGE_HOLD : bubble ? STAGE_BUBBLE : STAGE_LOAD;

    // invalid entries always carry an all-zero bundle
    always_ff @(posedge clk)
        if (rst || op == STAGE_CLEAR || op == STAGE_BUBBLE) begin
            ctrl  <= '0;
            valid <= 1'b0;
        end else if (op == STAGE_LOAD) begin
            ctrl  <= ctrl_in & {CW{valid_in}} & mask;
            valid <= valid_in;
        end
endmodule

// File: rtl/ctrl_pipe.sv
// ctrl_pipe: control bundle pipeline decode->E/M/W with stall, flush, bubbles and masking; CTRL_PIPE_PERF_EN adds bubble/stall counters
module ctrl_pipe
    import ctrl_pipe_pkg::*;
#(
    parameter int                       CW         = CTRL_CW,
    parameter int                       NSTAGE     = CTRL_NSTAGE,
    parameter logic [NSTAGE*CW-1:0]     STAGE_MASK = {NSTAGE*CW{1'b1}}
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [CW-1:0]        ctrl_d_i,
    input  logic                 valid_d_i,
    input  logic                 stall_d_i,
    input  logic [NSTAGE-1:0]    stall_i,
    input  logic [NSTAGE-1:0]    flush_i,
    output logic [NSTAGE*CW-1:0] ctrl_o,
    output logic [NSTAGE-1:0]    valid_o,
    output logic [NSTAGE-1:0]    hold_o,
    output logic                 stall_up_o,
    output logic [31:0]          bubble_cnt_o,
    output logic [31:0]          stall_cnt_o
);
    logic [NSTAGE-1:0] bubble;

    assign stall_up_o = hold_o[0];

    for (genvar k = 0; k < NSTAGE; k++) begin : g_stage
        logic          up_stall;
        logic [CW-1:0] src_ctrl;
        logic          src_valid;
        if (k == 0) begin : g_head
            assign up_stall  = stall_d_i;
            assign src_ctrl  = ctrl_d_i;
            assign src_valid = valid_d_i;
        end else begin : g_tail
            assign up_stall  = stall_i[k-1];
            assign src_ctrl  = ctrl_o[(k-1)*CW +: CW];
            assign src_valid = valid_o[k-1];
        end
        // any stall at or below this stage freezes it in the same cycle
        assign hold_o[k] = |(stall_i >> k);
        assign bubble[k] = up_stall & ~hold_o[k] & ~flush_i[k];
        ctrl_pipe_stage #(.CW(CW)) u_stage (
            .clk      (clk),
            .rst      (rst),
            .flush    (flush_i[k]),
            .hold     (hold_o[k]),
            .bubble   (bubble[k]),
            .ctrl_in  (src_ctrl),
            .valid_in (src_valid),
            .mask     (STAGE_MASK[k*CW +: CW]),
            .ctrl     (ctrl_o[k*CW +: CW]),
            .valid    (valid_o[k])
        );
    end

`ifdef CTRL_PIPE_PERF_EN
    logic [31:0] bubble_cnt, stall_cnt, bubble_sum;

    // number of stages inserting a bubble this cycle
    always_comb begin
        bubble_sum = '0;
        for (int i = 0; i < NSTAGE; i++) bubble_sum = bubble_sum + 32'(bubble[i]);
    end

    // free-running wrap-around performance counters
    always_ff @(posedge clk)
        if (rst) begin
            bubble_cnt <= '0;
            stall_cnt  <= '0;
        end else begin
            bubble_cnt <= bubble_cnt + bubble_sum;
            stall_cnt  <= stall_cnt + 32'(stall_up_o);
        end

    assign bubble_cnt_o = bubble_cnt;
    assign stall_cnt_o  = stall_cnt;
`else
    assign bubble_cnt_o = '0;
    assign stall_cnt_o  = '0;
`endif
endmodule

// File: tb/tb_ctrl_pipe.sv
// tb_ctrl_pipe: scoreboard bench for ctrl_pipe with directed and random stimulus against a reference model
module tb_ctrl_pipe;
    localparam int CW = 13;
    localparam int NS = 3;
    localparam logic [NS*CW-1:0] MASKS = {13'h1100, 13'h1900, 13'h1FFF};

    typedef struct {
        logic [NS*CW-1:0] ctrl;
        logic [NS-1:0]    valid;
        logic [NS-1:0]    hold;
        logic             up;
        logic [31:0]      bcnt;
        logic [31:0]      scnt;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst;
    logic [CW-1:0]    ctrl_d;
    logic             valid_d;
    logic             stall_d;
    logic [NS-1:0]    stall;
    logic [NS-1:0]    flush;
    logic [NS*CW-1:0] ctrl_o;
    logic [NS-1:0]    valid_o;
    logic [NS-1:0]    hold_o;
    logic             stall_up;
    logic [31:0]      bubble_cnt;
    logic [31:0]      stall_cnt;

    exp_t        q[$];
    int          checks = 0;
    int          errors = 0;
    logic [CW-1:0] m_ctrl[NS];
    logic          m_valid[NS];
    logic [31:0]   m_b = 0;
    logic [31:0]   m_s = 0;

    ctrl_pipe #(.CW(CW), .NSTAGE(NS), .STAGE_MASK(MASKS)) dut (
        .clk          (clk),
        .rst          (rst),
        .ctrl_d_i     (ctrl_d),
        .valid_d_i    (valid_d),
        .stall_d_i    (stall_d),
        .stall_i      (stall),
        .flush_i      (flush),
        .ctrl_o       (ctrl_o),
        .valid_o      (valid_o),
        .hold_o       (hold_o),
        .stall_up_o   (stall_up),
        .bubble_cnt_o (bubble_cnt),
        .stall_cnt_o  (stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, want);
        end
    endtask

    // apply one cycle of inputs, advance the reference model, queue what the DUT must show after the edge
    task automatic cycle(input logic r, input logic [CW-1:0] cd, input logic vd, input logic sd,
                         input logic [NS-1:0] st, input logic [NS-1:0] fl);
        exp_t          e;
        logic [CW-1:0] nc[NS];
        logic          nv[NS];
        logic [CW-1:0] sc;
        logic          sv, up, frozen;
        int            bubbles = 0;
        rst = r; ctrl_d = cd; valid_d = vd; stall_d = sd; stall = st; flush = fl;
        for (int k = 0; k < NS; k++) begin
            frozen = 1'b0;
            for (int j = k; j < NS; j++) if (st[j]) frozen = 1'b1;
            e.hold[k] = frozen;
            if (k == 0) begin
                up = sd; sc = cd; sv = vd;
            end else begin
                up = st[k-1]; sc = m_ctrl[k-1]; sv = m_valid[k-1];
            end
            if (r || fl[k]) begin
                nc[k] = '0; nv[k] = 1'b0;
            end else if (frozen) begin
                nc[k] = m_ctrl[k]; nv[k] = m_valid[k];
            end else if (up) begin
                nc[k] = '0; nv[k] = 1'b0; bubbles++;
            end else begin
                nv[k] = sv;
                nc[k] = sv ? (sc & MASKS[k*CW +: CW]) : '0;
            end
        end
        if (r) begin
            m_b = 0; m_s = 0;
        end else begin
            m_b = m_b + 32'(bubbles);
            m_s = m_s + (e.hold[0] ? 32'd1 : 32'd0);
        end
        for (int k = 0; k < NS; k++) begin
            m_ctrl[k] = nc[k]; m_valid[k] = nv[k];
            e.ctrl[k*CW +: CW] = nc[k];
            e.valid[k] = nv[k];
        end
        e.up = e.hold[0];
`ifdef CTRL_PIPE_PERF_EN
        e.bcnt = m_b;
        e.scnt = m_s;
`else
        e.bcnt = 0;
        e.scnt = 0;
`endif
        q.push_back(e);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(0, CW'($urandom), 0, 0, 0, 0);
    endtask

    function automatic logic [NS-1:0] rnd_bits(input int one_in);
        logic [NS-1:0] b;
        for (int i = 0; i < NS; i++) b[i] = ($urandom_range(0, one_in - 1) == 0);
        return b;
    endfunction

    // monitor: outputs are presented every cycle, compare against the oldest queued expectation
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("ctrl_o", 64'(ctrl_o), 64'(e.ctrl));
                chk("valid_o", 64'(valid_o), 64'(e.valid));
                chk("hold_o", 64'(hold_o), 64'(e.hold));
                chk("stall_up_o", 64'(stall_up), 64'(e.up));
                chk("bubble_cnt_o", 64'(bubble_cnt), 64'(e.bcnt));
                chk("stall_cnt_o", 64'(stall_cnt), 64'(e.scnt));
            end
        end
    end

    initial begin
        int wait_cycles;
        cycle(1, 0, 0, 0, 0, 0);
        cycle(1, 0, 0, 0, 0, 0);
        cycle(0, 13'h1AB, 1, 0, 0, 0);
        idle(3);
        cycle(0, 13'h1FFF, 1, 0, 0, 0);
        idle(3);
        for (int i = 0; i < 2; i++) cycle(0, CW'($urandom), 1, 0, 0, 0);
        for (int i = 0; i < 2; i++) cycle(0, CW'($urandom), 1, 1, 0, 0);
        for (int i = 0; i < 2; i++) cycle(0, CW'($urandom), 1, 0, 0, 0);
        for (int i = 0; i < 3; i++) cycle(0, CW'($urandom), 1, 0, 3'b010, 0);
        idle(1);
        cycle(0, 13'h0A5A, 1, 0, 0, 0);
        cycle(0, CW'($urandom), 1, 0, 3'b001, 3'b001);
        idle(2);
        cycle(0, CW'($urandom), 1, 0, 0, 0);
        cycle(0, CW'($urandom), 1, 0, 3'b010, 0);
        cycle(1, CW'($urandom), 1, 0, 3'b010, 0);
        idle(2);
        for (int i = 0; i < 400; i++)
            cycle($urandom_range(0, 49) == 0, CW'($urandom), 1'($urandom), $urandom_range(0, 3) == 0,
                  rnd_bits(5), rnd_bits(8));
        idle(3);
        wait_cycles = 0;
        while (q.size() > 0 && wait_cycles < 10) begin
            @(negedge clk);
            wait_cycles++;
        end
        if (q.size() > 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, expected 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/ctrl_pipe.md
Name: ctrl_pipe

Overview:
- Parametrised control-signal pipeline for the MIPS core.
- Carries the decoded control bundle from decode through NSTAGE downstream stages (default E/M/W).
- Adds per-stage valid bits, per-stage stall and flush, bubble insertion, stall back-propagation and per-stage bit masking.
- Sits between maindec/aludec outputs and the datapath; replaces hand-written fixed-width control flops.

Parameters:
- CW, 13: control bundle width in bits.
- NSTAGE, 3: number of pipeline stages after decode (stage 0 = E, 1 = M, 2 = W).
- STAGE_MASK, all ones ({NSTAGE*CW{1'b1}}): bit k*CW+i set means bit i is carried into stage k; cleared bits are forced 0 in that stage.

Ports:
- clk  in  1  core clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- ctrl_d_i  in  CW  control bundle from decode.
- valid_d_i  in  1  decode holds a real instruction.
- stall_d_i  in  1  decode stage is stalled (e.g. load-use); stage 0 receives a bubble.
- stall_i  in  NSTAGE  stall request per stage.
- flush_i  in  NSTAGE  flush request per stage.
- ctrl_o  out  NSTAGE*CW  stage k bundle at bits [k*CW +: CW].
- valid_o  out  NSTAGE  per-stage valid.
- hold_o  out  NSTAGE  effective hold per stage.
- stall_up_o  out  1  freeze request to fetch/decode (= hold_o[0]).
- bubble_cnt_o  out  32  bubbles inserted (optional feature).
- stall_cnt_o  out  32  cycles with stall_up_o high (optional feature).

Behaviour:
- One clock; reset is synchronous and active-high.
- On rst, all ctrl_o = 0, valid_o = 0 and counters = 0. rst overrides every other input.
- hold_o[k] = OR of stall_i[k..NSTAGE-1]; it is combinational, so a downstream stall freezes all upstream stages in the same cycle.
- Upstream stall for stage k: stall_d_i when k = 0, otherwise stall_i[k-1].
- Per-stage next-state priority, applied at every rising edge:
  1. rst.
  2. flush_i[k]: valid 0, ctrl 0. Flush beats hold.
  3. hold_o[k]: retain current ctrl and valid.
  4. Upstream stall with stage k not held: insert a bubble (valid 0, ctrl 0); counts as a bubble.
  5. Otherwise advance: stage 0 loads ctrl_d_i with valid_d_i; stage k loads stage k-1.
- On load, the incoming ctrl is ANDed with the incoming valid replicated, then with STAGE_MASK for stage k. An invalid entry therefore always carries ctrl 0.
- Latency: a decode bundle appears on stage k outputs k+1 cycles after capture, with no stalls.
- Stall and flush on the same stage: flush wins; the upstream stage stays held if its own hold is set.
- Flush of stage k with stage k+1 not held: stage k+1 loads the old stage-k contents that cycle (normal advance); the flush only kills stage k.
- No combinational path from ctrl_d_i to ctrl_o.
- Reset mid-stall clears everything; the next cycle behaves as an empty pipe.

Optional Feature:
- Macro: CTRL_PIPE_PERF_EN.
- Defined: bubble_cnt_o increments by the number of stages taking rule 4 that cycle (0..NSTAGE). stall_cnt_o increments by 1 each cycle stall_up_o is high. Both wrap modulo 2^32 and reset to 0.
- Undefined: both ports remain present and are tied to 0; no counter flops are synthesised.

Decomposition:
- Package ctrl_pipe_pkg holds:
  - CTRL_CW = 13 and CTRL_NSTAGE = 3;
  - stage indices STG_E = 0, STG_M = 1, STG_W = 2;
  - bundle bit positions: memtoreg 12, memwrite 11, alusrc 10, regdst 9, regwrite 8, alucontrol 7:0;
  - default STAGE_MASK constants (M keeps memtoreg/memwrite/regwrite; W keeps memtoreg/regwrite).
- One sub-module, ctrl_pipe_stage: a single CW-wide register plus valid, with rst/flush/hold/bubble/load priority and a mask input. It is instantiated NSTAGE times by generate.

Test Plan:
- Reset, then stream: hold rst 2 cycles, then drive ctrl_d_i = 0x1AB, valid_d_i = 1 for one cycle -> stage 0 = 0x1AB at cycle 1, stage 1 at cycle 2, stage 2 at cycle 3; all valids 0 before arrival.
- Masking: with default package masks, send 0x1FFF -> E = 0x1FFF, M = 0x1900, W = 0x1100.
- Decode stall: stall_d_i = 1 for 2 cycles while streaming -> stage 0 gets two bubbles (valid 0, ctrl 0); M/W advance; bubble_cnt_o = 2 with macro on.
- Downstream stall: stall_i = 3'b010 for 3 cycles -> hold_o = 3'b011, stall_up_o = 1; E and M frozen; W receives 3 bubbles; stall_cnt_o = 3.
- Flush vs stall: stall_i[0] = 1 and flush_i[0] = 1 in the same cycle with E valid -> E becomes valid 0, ctrl 0; M receives a bubble.
- Reset mid-stall: assert rst during an active stall_i -> next cycle all outputs 0 and counters 0.
